spi_adc_scanner: RTL and testbench

Parametrised SPI scanner for MCP320x-family successive-approximation ADCs: single-ended conversions, round-robin over a masked channel set, results held in per-channel registers. Generalises the two-channel MCP3202 reader to N channels, configurable resolution, SCLK rate and inter-frame gap, with an optional per-channel peak-hold. Runs on the low-speed housekeeping clock; outputs feed the Tx-side status (forward/reverse power, supply and temperature sensing).

---
 rtl/spi_adc_scanner.sv | 193 +++++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adc_scanner.sv
// Round-robin SPI scanner for MCP320x single-ended ADCs with per-channel result registers.
// Optional per-channel peak-hold is built when SPI_ADC_PEAK_HOLD_EN is defined.
module spi_adc_scanner #(
  parameter int NUM_CH   = 8,
  parameter int CH_BITS  = 3,
  parameter int ADC_BITS = 12,
  parameter int CLK_DIV  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_mask,
  output logic                         SCLK,
  output logic                         nCS,
  output logic                         MOSI,
  input  logic                         MISO,
  output logic [NUM_CH*ADC_BITS-1:0]   ain,
  output logic                         ain_valid,
  output logic [CH_BITS-1:0]           ain_ch,
  output logic [NUM_CH*ADC_BITS-1:0]   peak,
  input  logic                         pk_detect_reset,
  output logic                         pk_detect_ack
);

  localparam int NBITS  = 4 + CH_BITS + ADC_BITS;
  localparam int DSTART = 4 + CH_BITS;

  localparam logic [15:0] DIV_END = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_END = 16'(CS_IDLE - 1);
  localparam logic [4:0]  D_FIRST = 5'(DSTART);
  localparam logic [4:0]  B_LAST  = 5'(NBITS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCLK_HI,
    SCLK_LO,
    DONE,
    GAP
  } state_t;

  state_t                state;
  logic [15:0]           cnt;
  logic [4:0]            bit_idx;
  logic [NBITS-1:0]      tx;
  logic [ADC_BITS-1:0]   rx;
  logic [CH_BITS-1:0]    cur_ch;
  logic [CH_BITS-1:0]    nxt_ch;
  logic [CH_BITS-1:0]    hi_ch;
  logic [CH_BITS-1:0]    lo_ch;
  logic                  hi_ok;
  logic [ADC_BITS-1:0]   ain_r [NUM_CH];

  // Next set mask bit strictly above cur_ch, else the lowest set bit.
  always_comb begin
    hi_ok = 1'b0;
    hi_ch = '0;
    lo_ch = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (ch_mask[j]) begin
        lo_ch = CH_BITS'(j);
        if (j > int'(cur_ch)) begin
          hi_ch = CH_BITS'(j);
          hi_ok = 1'b1;
        end
      end
    end
    nxt_ch = hi_ok ? hi_ch : lo_ch;
  end

  assign MOSI = tx[NBITS-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      tx        <= '0;
      rx        <= '0;
      cur_ch    <= CH_BITS'(NUM_CH - 1);
      SCLK      <= 1'b0;
      nCS       <= 1'b1;
      ain_valid <= 1'b0;
      ain_ch    <= '0;
      for (int i = 0; i < NUM_CH; i++)
        ain_r[i] <= '0;
    end else begin
      ain_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && ch_mask != '0) begin
            cur_ch  <= nxt_ch;
            tx      <= {2'b11, nxt_ch,
                        {(NBITS-2-CH_BITS){1'b0}}};
            nCS     <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == DIV_END) begin
            cnt   <= '0;
            SCLK  <= 1'b1;
            state <= SCLK_HI;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SCLK_HI: begin
          if (cnt == DIV_END) begin
            cnt     <= '0;
            SCLK    <= 1'b0;
            if (bit_idx >= D_FIRST)
              rx <= {rx[ADC_BITS-2:0], MISO};
            tx      <= {tx[NBITS-2:0], 1'b0};
            bit_idx <= bit_idx + 5'd1;
            state   <= SCLK_LO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SCLK_LO: begin
          if (cnt == DIV_END) begin
            cnt <= '0;
            if (bit_idx == B_LAST) begin
              nCS   <= 1'b1;
              state <= DONE;
            end else begin
              SCLK  <= 1'b1;
              state <= SCLK_HI;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_CH; i++)
            if (cur_ch == CH_BITS'(i))
              ain_r[i] <= rx;
          ain_ch    <= cur_ch;
          ain_valid <= 1'b1;
          cnt       <= '0;
          state     <= GAP;
        end
        GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ain
    assign ain[g*ADC_BITS +: ADC_BITS] = ain_r[g];
  end

  always_ff @(posedge clock) begin
    if (reset)
      pk_detect_ack <= 1'b0;
    else
      pk_detect_ack <= pk_detect_reset;
  end

`ifdef SPI_ADC_PEAK_HOLD_EN
  logic [ADC_BITS-1:0] pk_r [NUM_CH];

  // A clear request beats a same-cycle result for the peak registers.
  always_ff @(posedge clock) begin
    if (reset || pk_detect_reset) begin
      for (int i = 0; i < NUM_CH; i++)
        pk_r[i] <= '0;
    end else if (state == DONE) begin
      for (int i = 0; i < NUM_CH; i++)
        if (cur_ch == CH_BITS'(i) && rx > pk_r[i])
          pk_r[i] <= rx;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pk
    assign peak[g*ADC_BITS +: ADC_BITS] = pk_r[g];
  end
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Scoreboard bench for spi_adc_scanner: ADC model on the SPI pins,
// expected results queued at address decode and matched on ain_valid.
module tb_spi_adc_scanner;

  localparam int NUM_CH   = 8;
  localparam int CH_BITS  = 3;
  localparam int ADC_BITS = 12;
  localparam int CLK_DIV  = 2;
  localparam int CS_IDLE  = 4;
  localparam int NBITS    = 4 + CH_BITS + ADC_BITS;
  localparam int DSTART   = 4 + CH_BITS;
  localparam int PERIOD   = CLK_DIV*(1+2*NBITS) + 1 + CS_IDLE + 1;

  logic                       clock;
  logic                       reset;
  logic                       enable;
  logic [NUM_CH-1:0]          ch_mask;
  logic                       sclk;
  logic                       ncs;
  logic                       mosi;
  logic                       miso;
  logic [NUM_CH*ADC_BITS-1:0] ain;
  logic                       ain_valid;
  logic [CH_BITS-1:0]         ain_ch;
  logic [NUM_CH*ADC_BITS-1:0] peak;
  logic                       pk_req;
  logic                       pk_ack;

  spi_adc_scanner #(
    .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .ADC_BITS(ADC_BITS),
    .CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .ch_mask(ch_mask), .SCLK(sclk), .nCS(ncs),
    .MOSI(mosi), .MISO(miso), .ain(ain),
    .ain_valid(ain_valid), .ain_ch(ain_ch), .peak(peak),
    .pk_detect_reset(pk_req), .pk_detect_ack(pk_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [CH_BITS-1:0]  ch;
    logic [ADC_BITS-1:0] val;
  } exp_t;

  exp_t                sb[$];
  int                  total = 0;
  int                  bad = 0;
  logic [ADC_BITS-1:0] adc_val [NUM_CH];
  logic [ADC_BITS-1:0] pk_m [NUM_CH];
  logic [ADC_BITS-1:0] cur_val;
  logic [CH_BITS-1:0]  addr;
  int                  k;
  int                  exp_last;
  int                  n_valid;
  longint              cyc = 0;
  longint              last_fall;
  bit                  fall_ok;
  bit                  chk_period;
  logic                ncs_p, sclk_p;
  logic                rst_e, pk_e, pk_e_d;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int next_ch(input int last,
                                 input logic [NUM_CH-1:0] m);
    for (int i = 1; i <= NUM_CH; i++) begin
      if (m[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    cyc++;
    rst_e  = reset;
    pk_e_d = pk_e;
    pk_e   = pk_req;
  end

  // ADC model, scoreboard and peak model, all on the falling edge.
  always @(negedge clock) begin
    int b;
    int e;
    exp_t ent;
    logic [NUM_CH*ADC_BITS-1:0] pv;
    if (rst_e) begin
      sb.delete();
      exp_last = NUM_CH - 1;
      k = 0;
      fall_ok = 0;
      for (int i = 0; i < NUM_CH; i++) pk_m[i] = '0;
    end else begin
      if (ncs_p && !ncs) begin
        if (chk_period && fall_ok)
          check("period", 128'(cyc - last_fall), PERIOD);
        last_fall = cyc;
        fall_ok = chk_period;
        k = 0;
      end
      if (!sclk_p && sclk && !ncs) begin
        b = k;
        k++;
        if (b < 2) begin
          check(b == 0 ? "start" : "sgl", mosi, 1);
        end else if (b < 2 + CH_BITS) begin
          addr = {addr[CH_BITS-2:0], mosi};
          if (b == 1 + CH_BITS) begin
            e = next_ch(exp_last, ch_mask);
            check("addr", addr, e);
            exp_last = e;
            cur_val = adc_val[addr];
            sb.push_back('{ch: addr, val: cur_val});
          end
        end else begin
          check("mosi_zero", mosi, 0);
        end
        if (b >= DSTART && b < NBITS)
          miso = cur_val[ADC_BITS-1-(b-DSTART)];
        else
          miso = 1'b1;
      end
      if (!ncs_p && ncs) check("pulses", k, NBITS);
      if (ain_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          check("sb_empty", 0, 1);
        end else begin
          ent = sb.pop_front();
          check("ain_ch", ain_ch, ent.ch);
          check("ain", ain[ent.ch*ADC_BITS +: ADC_BITS], ent.val);
`ifdef SPI_ADC_PEAK_HOLD_EN
          if (!pk_e && ent.val > pk_m[ent.ch]) pk_m[ent.ch] = ent.val;
`endif
        end
      end
      if (pk_e)
        for (int i = 0; i < NUM_CH; i++) pk_m[i] = '0;
      if (ain_valid || pk_e) begin
        for (int i = 0; i < NUM_CH; i++)
          pv[i*ADC_BITS +: ADC_BITS] = pk_m[i];
        check("peak", peak, pv);
      end
      if (pk_e || pk_e_d || pk_ack) check("ack", pk_ack, pk_e);
    end
    ncs_p  = ncs;
    sclk_p = sclk;
  end

  task automatic wait_valid(input int target);
    int t = 0;
    while (n_valid < target && t < 3000) begin
      @(negedge clock);
      t++;
    end
    check("valid_cnt", n_valid, target);
  endtask

  task automatic wait_pulse(input int kk);
    int t = 0;
    while (!(!ncs && k >= kk) && t < 500) begin
      @(negedge clock);
      t++;
    end
    check("pulse_wait", (!ncs && k >= kk), 1);
  endtask

  initial begin
    int n0, viol, ackn, t;
    reset = 1; enable = 0; ch_mask = '0; miso = 0; pk_req = 0;
    chk_period = 0; n_valid = 0; exp_last = NUM_CH - 1;
    ncs_p = 1; sclk_p = 0; pk_e = 0; pk_e_d = 0; rst_e = 1;
    for (int i = 0; i < NUM_CH; i++) begin
      adc_val[i] = ADC_BITS'(12'h100 + i * 12'h11);
      pk_m[i] = '0;
    end
    adc_val[0] = 12'hABC;
    adc_val[2] = 12'h123;
    repeat (5) @(negedge clock);
    check("rst_ncs", ncs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ain", ain, 0);
    check("rst_valid", ain_valid, 0);
    check("rst_ain_ch", ain_ch, 0);
    check("rst_peak", peak, 0);
    check("rst_ack", pk_ack, 0);
    reset = 0;

    ch_mask = 8'h05; chk_period = 1; enable = 1;
    wait_valid(n_valid + 4);
    check("ain_ch0", ain[11:0], 12'hABC);
    check("ain_ch2", ain[35:24], 12'h123);

    ch_mask = 8'hA1;
    wait_valid(n_valid + 4);
    ch_mask = 8'h08; adc_val[3] = 12'h5A5;
    wait_valid(n_valid + 2);
    check("ain_ch3", ain[47:36], 12'h5A5);

    wait_pulse(5);
    chk_period = 0; enable = 0; n0 = n_valid; viol = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (n_valid > n0 && (!ncs || sclk)) viol++;
    end
    check("drop_valid", n_valid - n0, 1);
    check("drop_idle", viol, 0);

    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    check("ain_clr", ain, 0);
    ch_mask = 8'h06; enable = 1;
    wait_pulse(10);
    n0 = n_valid;
    reset = 1;
    @(negedge clock);
    check("abort_ncs", ncs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_ain", ain, 0);
    check("abort_valid", ain_valid, 0);
    repeat (2) @(negedge clock);
    check("abort_nv", n_valid - n0, 0);
    reset = 0;
    wait_valid(n_valid + 2);
    check("ain_ch1", ain[23:12], adc_val[1]);

    ch_mask = 8'h02; adc_val[1] = 12'd100;
    wait_valid(n_valid + 1);
    adc_val[1] = 12'd300;
    wait_valid(n_valid + 1);
    adc_val[1] = 12'd200;
    wait_valid(n_valid + 1);
`ifdef SPI_ADC_PEAK_HOLD_EN
    check("peak_ch1", peak[23:12], 12'd300);
`else
    check("peak_off", peak, 0);
`endif
    check("ain_last", ain[23:12], 12'd200);

    adc_val[1] = 12'd50;
    t = 0;
    while (ncs && t < 500) begin @(negedge clock); t++; end
    while (!ncs && t < 1000) begin @(negedge clock); t++; end
    check("done_wait", ncs, 1);
    pk_req = 1; ackn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (pk_ack) ackn++;
      if (i == 2) pk_req = 0;
    end
    check("ack_cnt", ackn, 3);
    check("peak_clr", peak, 0);
    check("ain_clr_frame", ain[23:12], 12'd50);

    wait_valid(n_valid + 1);
    ch_mask = '0; viol = 0;
    repeat (10) @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!ncs || sclk) viol++;
    end
    check("mask0_idle", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
